// File: rtl/trap_sequencer.sv
// Interrupt arbiter and trap-entry/mret sequencer for the 3-stage core.
// Timer and external requests are arbitrated here; the csr block and PC-select logic follow the strobes.
module trap_sequencer #(
    parameter int unsigned RET_HOLDOFF = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        t_intr,
    input  logic        e_intr,
    input  logic        mie_mtie,
    input  logic        mie_meie,
    input  logic        mstatus_mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc_in,
    input  logic [31:0] pc_ex,
    input  logic        is_mret,
    output logic        stall,
    output logic        flush,
    output logic        trap_wr,
    output logic [31:0] trap_mepc,
    output logic [31:0] trap_mcause,
    output logic        mie_clr,
    output logic        mie_set,
    output logic        pc_redir,
    output logic [31:0] pc_target,
    output logic        t_ack,
    output logic        e_ack,
    output logic        in_trap
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_REDIRECT,
        S_HANDLER,
        S_RETURN
    } state_t;

    // The RETURN cycle itself counts as the first hold-off cycle, so the
    // counter starts one below the configured value.
    localparam logic [3:0] HOLD_LOAD = (RET_HOLDOFF == 0) ? 4'd0 : 4'(RET_HOLDOFF - 1);

    state_t      r_state;
    logic [3:0]  r_holdoff;
    logic        r_cause_ext;

    logic        w_ext_req;
    logic        w_tim_req;
    logic        w_take;
    logic [31:0] w_base;
    logic [31:0] w_offset;
    logic [31:0] w_vector;

    assign w_ext_req = e_intr & mie_meie;
    assign w_tim_req = t_intr & mie_mtie;
    assign w_take    = mstatus_mie & (w_ext_req | w_tim_req) & (r_holdoff == 4'd0);

    // Vectored offset is cause[30:0]<<2: 11*4 for external, 7*4 for timer.
    assign w_base   = {mtvec[31:2], 2'b00};
    assign w_offset = r_cause_ext ? 32'h0000_002C : 32'h0000_001C;
    assign w_vector = (mtvec[1:0] == 2'b01) ? (w_base + w_offset) : w_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_holdoff   <= 4'd0;
            r_cause_ext <= 1'b0;
            stall       <= 1'b0;
            flush       <= 1'b0;
            trap_wr     <= 1'b0;
            trap_mepc   <= 32'd0;
            trap_mcause <= 32'd0;
            mie_clr     <= 1'b0;
            mie_set     <= 1'b0;
            pc_redir    <= 1'b0;
            pc_target   <= 32'd0;
            t_ack       <= 1'b0;
            e_ack       <= 1'b0;
            in_trap     <= 1'b0;
        end else begin
            stall    <= 1'b0;
            flush    <= 1'b0;
            trap_wr  <= 1'b0;
            mie_clr  <= 1'b0;
            mie_set  <= 1'b0;
            pc_redir <= 1'b0;
            t_ack    <= 1'b0;
            e_ack    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_holdoff != 4'd0) r_holdoff <= r_holdoff - 4'd1;
                    if (is_mret) begin
                        r_state   <= S_RETURN;
                        flush     <= 1'b1;
                        pc_redir  <= 1'b1;
                        pc_target <= mepc_in;
                        mie_set   <= 1'b1;
                    end else if (w_take) begin
                        r_state     <= S_SAVE;
                        stall       <= 1'b1;
                        flush       <= 1'b1;
                        trap_wr     <= 1'b1;
                        mie_clr     <= 1'b1;
                        in_trap     <= 1'b1;
                        r_cause_ext <= w_ext_req;
                        trap_mepc   <= pc_ex;
                        trap_mcause <= w_ext_req ? 32'h8000_000B : 32'h8000_0007;
                    end
                end
                S_SAVE: begin
                    r_state   <= S_REDIRECT;
                    stall     <= 1'b1;
                    pc_redir  <= 1'b1;
                    pc_target <= w_vector;
                    e_ack     <= r_cause_ext;
                    t_ack     <= ~r_cause_ext;
                end
                S_REDIRECT: begin
                    r_state <= S_HANDLER;
                end
                S_HANDLER: begin
                    if (is_mret) begin
                        r_state   <= S_RETURN;
                        flush     <= 1'b1;
                        pc_redir  <= 1'b1;
                        pc_target <= mepc_in;
                        mie_set   <= 1'b1;
                        in_trap   <= 1'b0;
                    end
                end
                S_RETURN: begin
                    r_state   <= S_IDLE;
                    r_holdoff <= HOLD_LOAD;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios plus randomized traffic against a timestamp-based model.
module tb_trap_sequencer;
    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        t_intr, e_intr, mie_mtie, mie_meie, mstatus_mie, is_mret;
    logic [31:0] mtvec, mepc_in, pc_ex;
    logic        stall, flush, trap_wr, mie_clr, mie_set, pc_redir, t_ack, e_ack, in_trap;
    logic [31:0] trap_mepc, trap_mcause, pc_target;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: each event of the trap/return sequence is a cycle timestamp.
    int          cyc;
    int          save_at, ret_at, open_at, close_at, last_ret;
    bit          trap_open, m_ext;
    logic [31:0] m_mepc, m_mcause, redir_tgt, ret_tgt;

    trap_sequencer #(.RET_HOLDOFF(HOLD)) dut (
        .clk(clk), .rst(rst), .t_intr(t_intr), .e_intr(e_intr),
        .mie_mtie(mie_mtie), .mie_meie(mie_meie), .mstatus_mie(mstatus_mie),
        .mtvec(mtvec), .mepc_in(mepc_in), .pc_ex(pc_ex), .is_mret(is_mret),
        .stall(stall), .flush(flush), .trap_wr(trap_wr), .trap_mepc(trap_mepc),
        .trap_mcause(trap_mcause), .mie_clr(mie_clr), .mie_set(mie_set),
        .pc_redir(pc_redir), .pc_target(pc_target), .t_ack(t_ack), .e_ack(e_ack),
        .in_trap(in_trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] vec(input logic [31:0] tv, input bit ext);
        logic [31:0] base;
        base = tv & 32'hFFFF_FFFC;
        if (tv[1:0] == 2'b01) return base + (ext ? 32'd11 : 32'd7) * 32'd4;
        return base;
    endfunction

    task automatic model_reset();
        save_at   = -1000;
        ret_at    = -1000;
        last_ret  = -1000;
        open_at   = 0;
        close_at  = 0;
        trap_open = 0;
        m_ext     = 0;
        m_mepc    = 32'd0;
        m_mcause  = 32'd0;
    endtask

    task automatic decide();
        int hold_min;
        hold_min = (HOLD < 1) ? 1 : HOLD;
        if (cyc == save_at) begin
            redir_tgt = vec(mtvec, m_ext);
        end else if (cyc == save_at + 1 || cyc == ret_at) begin
            // sequence step in flight, inputs ignored
        end else if (is_mret) begin
            ret_at   = cyc + 1;
            ret_tgt  = mepc_in;
            last_ret = cyc + 1;
            if (trap_open) begin
                close_at  = cyc + 1;
                trap_open = 0;
            end
        end else if (!trap_open && mstatus_mie && ((e_intr && mie_meie) || (t_intr && mie_mtie))
                     && (cyc - last_ret >= hold_min)) begin
            save_at   = cyc + 1;
            open_at   = cyc + 1;
            close_at  = 1 << 30;
            trap_open = 1;
            m_ext     = e_intr && mie_meie;
            m_mepc    = pc_ex;
            m_mcause  = m_ext ? 32'h8000_000B : 32'h8000_0007;
        end
    endtask

    task automatic step();
        bit is_save, is_redir, is_ret, it;
        logic [8:0] exp_v, got_v;
        decide();
        @(posedge clk);
        #1;
        cyc++;
        is_save  = (cyc == save_at);
        is_redir = (cyc == save_at + 1);
        is_ret   = (cyc == ret_at);
        it       = (cyc >= open_at) && (cyc < close_at);
        exp_v = {is_save | is_redir, is_save | is_ret, is_save, is_save, is_ret,
                 is_redir | is_ret, is_redir & ~m_ext, is_redir & m_ext, it};
        got_v = {stall, flush, trap_wr, mie_clr, mie_set, pc_redir, t_ack, e_ack, in_trap};
        chk("strobes", 32'(got_v), 32'(exp_v));
        chk("trap_mepc", trap_mepc, m_mepc);
        chk("trap_mcause", trap_mcause, m_mcause);
        if (is_redir || is_ret) chk("pc_target", pc_target, is_redir ? redir_tgt : ret_tgt);
        if (t_ack) t_intr = 1'b0;
        if (e_ack) e_intr = 1'b0;
    endtask

    task automatic finish_trap();
        is_mret = 1'b1;
        step();
        is_mret = 1'b0;
        repeat (3) step();
    endtask

    logic [31:0] mtvec_tab [4] = '{32'h0000_0100, 32'h0000_0101, 32'hFFFF_FFF1, 32'h0000_2003};

    initial begin
        int k;
        rst = 1'b1;
        {t_intr, e_intr, mie_mtie, mie_meie, mstatus_mie, is_mret} = '0;
        mtvec = 32'd0; mepc_in = 32'd0; pc_ex = 32'd0;
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_strobes", 32'({stall, flush, trap_wr, mie_clr, mie_set, pc_redir, t_ack, e_ack, in_trap}), 32'd0);
        chk("reset_mepc", trap_mepc, 32'd0);
        chk("reset_mcause", trap_mcause, 32'd0);
        chk("reset_target", pc_target, 32'd0);
        rst = 1'b0;

        // External interrupt, direct mode
        mtvec = 32'h100; pc_ex = 32'h40; mie_meie = 1'b1; mstatus_mie = 1'b1; e_intr = 1'b1;
        step();
        chk("t1_trap_wr", 32'(trap_wr), 32'd1);
        chk("t1_mepc", trap_mepc, 32'h40);
        chk("t1_mcause", trap_mcause, 32'h8000_000B);
        step();
        chk("t1_target", pc_target, 32'h100);
        chk("t1_e_ack", 32'(e_ack), 32'd1);
        step();
        mepc_in = 32'h40;
        finish_trap();

        // Simultaneous requests, vectored; timer follows after hold-off
        mtvec = 32'h101; mie_mtie = 1'b1; t_intr = 1'b1; e_intr = 1'b1;
        step();
        chk("t2_mcause_ext", trap_mcause, 32'h8000_000B);
        step();
        chk("t2_target_ext", pc_target, 32'h12C);
        chk("t2_no_t_ack", 32'(t_ack), 32'd0);
        step();
        is_mret = 1'b1;
        step();
        is_mret = 1'b0;
        chk("t2_return", 32'(mie_set), 32'd1);
        k = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (trap_wr) begin k = i; break; end
        end
        chk("t2_holdoff_cycles", 32'(k), 32'd3);
        chk("t2_mcause_tim", trap_mcause, 32'h8000_0007);
        step();
        chk("t2_target_tim", pc_target, 32'h11C);
        chk("t2_t_ack", 32'(t_ack), 32'd1);
        step();
        finish_trap();

        // Masked request stays pending until enabled
        mstatus_mie = 1'b0; e_intr = 1'b1;
        repeat (3) begin step(); chk("t3_masked_mie", 32'(trap_wr), 32'd0); end
        mstatus_mie = 1'b1; mie_meie = 1'b0;
        repeat (2) begin step(); chk("t3_masked_meie", 32'(trap_wr), 32'd0); end
        mie_meie = 1'b1;
        step();
        chk("t3_taken", 32'(trap_wr), 32'd1);
        repeat (2) step();
        finish_trap();

        // mret wins over a same-cycle take
        e_intr = 1'b1; is_mret = 1'b1; mepc_in = 32'h80;
        step();
        is_mret = 1'b0;
        chk("t4_target", pc_target, 32'h80);
        chk("t4_mie_set", 32'(mie_set), 32'd1);
        chk("t4_no_trap_wr", 32'(trap_wr), 32'd0);
        repeat (5) step();
        finish_trap();

        // Vector wraps modulo 2^32
        mtvec = 32'hFFFF_FFF1; e_intr = 1'b1;
        step();
        step();
        chk("t6_target_wrap", pc_target, 32'h0000_001C);
        step();
        finish_trap();

        // Asynchronous reset during REDIRECT
        mtvec = 32'h100; e_intr = 1'b1;
        step();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_strobes", 32'({stall, flush, trap_wr, mie_clr, mie_set, pc_redir, t_ack, e_ack, in_trap}), 32'd0);
        chk("t5_rst_mepc", trap_mepc, 32'd0);
        chk("t5_rst_target", pc_target, 32'd0);
        @(posedge clk);
        #1;
        chk("t5_rst_held_ack", 32'(e_ack), 32'd0);
        rst = 1'b0;
        model_reset();
        step();
        chk("t5_retrap", 32'(trap_wr), 32'd1);
        repeat (2) step();
        finish_trap();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!t_intr && $urandom_range(0, 7) == 0) t_intr = 1'b1;
            if (!e_intr && $urandom_range(0, 9) == 0) e_intr = 1'b1;
            if ($urandom_range(0, 40) == 0) t_intr = 1'b0;
            if ($urandom_range(0, 40) == 0) e_intr = 1'b0;
            mstatus_mie = ($urandom_range(0, 5) != 0);
            mie_mtie    = ($urandom_range(0, 4) != 0);
            mie_meie    = ($urandom_range(0, 4) != 0);
            is_mret     = ($urandom_range(0, 4) == 0);
            pc_ex       = $urandom;
            mepc_in     = $urandom;
            if ($urandom_range(0, 19) == 0) mtvec = mtvec_tab[$urandom_range(0, 3)];
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
